issue_scoreboard: RTL
=====================

# issue_scoreboard

- Sits between instruction decode and the execution pipes (ALU, MUL, DIV, LSU).
- Tracks architectural registers with an outstanding write and admits the decoded instruction to its target pipe only when it is hazard-free and the pipe can accept it.
- Otherwise asserts a stall back to the core.
- Holds per-register busy bits, a DIV occupancy flag and an LSU outstanding-request counter.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- REG_WIDTH, 5, register index width.
- LSU_MAX_OUTSTANDING, 4, maximum LSU requests in flight.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kill the instruction presented this cycle; no issue.
- id_valid  in  1  decoded instruction present.
- id_a1, id_a2  in  REG_WIDTH  source registers.
- id_rd  in  REG_WIDTH  destination register.
- id_register_write  in  1  instruction writes id_rd.
- id_exe_pipe  in  4  one-hot target: bit0 ALU, bit1 MUL, bit2 DIV, bit3 LSU; all-zero = invalid.
- wb_valid  in  4  per-pipe writeback/completion strobe, same bit order.
- wb_rd  in  4×REG_WIDTH  per-pipe completing destination register.
- lsu_done  in  1  LSU request retired; decrements the LSU counter.
- issue_valid  out  4  one-hot issue strobe to the selected pipe.
- stall  out  1  ID must hold its instruction.
- busy_regs  out  NUM_REGS  scoreboard snapshot.
- div_busy  out  1  DIV unit occupied.

## Operation
- Hazard check:
  - RAW: a non-zero id_a1 or id_a2 with its busy bit set blocks issue.
  - WAW: id_register_write with a non-zero id_rd whose busy bit is set blocks issue.
- Structural checks:
  - DIV target blocks issue while div_busy=1.
  - LSU target blocks issue while lsu_count == LSU_MAX_OUTSTANDING.
- can_issue = id_valid & ~flush & (id_exe_pipe != 0) & no hazard & no structural block.
- issue_valid = id_exe_pipe when can_issue, else 0.
- stall = id_valid & ~flush & (id_exe_pipe != 0) & ~can_issue.
- Invalid pipe encoding is dropped silently: no issue, no stall.
- On issue with id_register_write and id_rd≠0: busy[id_rd] sets at the next edge.
- On any wb_valid[p] with wb_rd[p]≠0: busy[wb_rd[p]] clears at the next edge. Multiple clears in one cycle all apply.
- Set and clear of the same register in one cycle: set wins.
- DIV: div_busy sets on DIV issue and clears on wb_valid[2].
- LSU counter:
  - increments on LSU issue, decrements on lsu_done.
  - Simultaneous increment and decrement leaves it unchanged.
  - Never wraps; decrement at 0 is ignored.
- flush affects only the current ID slot. Already-issued instructions keep their busy bits until writeback.
- Reset (asserted anywhere, including mid-operation): busy_regs=0, div_busy=0, lsu_count=0, issue_valid=0, stall=0.

## Timing
- Issue decision is combinational, with zero-cycle latency from id_* to issue_valid and stall.
- Scoreboard, div_busy and lsu_count update on the rising clk edge following the event.
- An instruction waiting on a register issues in the cycle after the producer's wb_valid. With SCOREBOARD_BYPASS_EN it issues in the same cycle.
- Back-to-back independent issues occur every cycle.
- While stalled, id_* is held stable by ID. Re-evaluation happens every cycle with no extra penalty.

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - The hazard check masks busy bits being cleared this cycle by wb_valid/wb_rd, so a consumer issues in the writeback cycle.
  - DIV issue is likewise allowed in the cycle wb_valid[2] is high; div_busy stays 1 for the new DIV.
- SCOREBOARD_BYPASS_EN undefined: only registered state is checked, so a consumer issues one cycle after writeback.

## Test plan
- Reset with instructions pending: assert rst=0 while busy_regs=0x0000_0010 and lsu_count=2 -> busy_regs=0, lsu_count=0, div_busy=0 immediately; after release, an ALU add x5,x1,x2 issues (issue_valid=4'b0001).
- RAW: MUL x3 issues, then ALU with a1=3 -> stall=1 until wb_valid[1] with wb_rd=3. Issue follows one cycle later without bypass, in the same cycle with SCOREBOARD_BYPASS_EN.
- DIV structural: DIV x7 issues, then DIV x8 -> stall=1 while div_busy=1. Meanwhile an ALU instruction with no dependency on x7 issues.
- LSU limit: five loads to x10..x14 with no lsu_done -> four issue and the fifth stalls. A single lsu_done releases it next cycle, and lsu_count returns to 4.
- x0 and flush:
  - ALU writing x0, then a reader of x0 -> both issue and busy_regs stays 0.
  - flush=1 with id_valid=1 -> issue_valid=0, stall=0, scoreboard unchanged.
- Simultaneous events: ALU writeback of x4 plus issue of a new write to x4 in the same cycle (bypass build) -> busy[4]=1 afterwards. LSU issue plus lsu_done in the same cycle -> lsu_count unchanged.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decode/writeback bundle between the core and the issue scoreboard.
interface issue_scoreboard_if #(
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 5
);
  logic                           flush;
  logic                           id_valid;
  logic [REG_WIDTH-1:0]           id_a1;
  logic [REG_WIDTH-1:0]           id_a2;
  logic [REG_WIDTH-1:0]           id_rd;
  logic                           id_register_write;
  logic [3:0]                     id_exe_pipe;
  logic [3:0]                     wb_valid;
  logic [3:0][REG_WIDTH-1:0]      wb_rd;
  logic                           lsu_done;
  logic [3:0]                     issue_valid;
  logic                           stall;
  logic [NUM_REGS-1:0]            busy_regs;
  logic                           div_busy;
  modport master (
    output flush, id_valid, id_a1, id_a2, id_rd, id_register_write, id_exe_pipe,
           wb_valid, wb_rd, lsu_done,
    input  issue_valid, stall, busy_regs, div_busy
  );
  modport slave (
    input  flush, id_valid, id_a1, id_a2, id_rd, id_register_write, id_exe_pipe,
           wb_valid, wb_rd, lsu_done,
    output issue_valid, stall, busy_regs, div_busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register busy tracking plus DIV/LSU structural checks gating issue to the pipes.
// Optional SCOREBOARD_BYPASS_EN lets same-cycle writebacks release waiting consumers.
module issue_scoreboard #(
  parameter int NUM_REGS            = 32,
  parameter int REG_WIDTH           = 5,
  parameter int LSU_MAX_OUTSTANDING = 4
) (
  input logic                  clk,
  input logic                  rst,
  issue_scoreboard_if.slave    sb
);
  localparam int CW = $clog2(LSU_MAX_OUTSTANDING + 1);
  logic [NUM_REGS-1:0] busy_q, busy_d, clr_mask, set_mask, hz_busy;
  logic                div_busy_q, div_busy_d, div_hz;
  logic [CW-1:0]       lsu_count_q, lsu_count_d;
  logic                raw, waw, struct_blk, req, can_issue, lsu_inc, lsu_dec;
  always_comb begin
    clr_mask = '0;
    for (int p = 0; p < 4; p++)
      if (sb.wb_valid[p] && sb.wb_rd[p] != '0) clr_mask[sb.wb_rd[p]] = 1'b1;
  end
`ifdef SCOREBOARD_BYPASS_EN
  assign hz_busy = busy_q & ~clr_mask;
  assign div_hz  = div_busy_q & ~sb.wb_valid[2];
`else
  assign hz_busy = busy_q;
  assign div_hz  = div_busy_q;
`endif
  assign raw        = (sb.id_a1 != '0 && hz_busy[sb.id_a1]) || (sb.id_a2 != '0 && hz_busy[sb.id_a2]);
  assign waw        = sb.id_register_write && sb.id_rd != '0 && hz_busy[sb.id_rd];
  assign struct_blk = (sb.id_exe_pipe[2] && div_hz) ||
                      (sb.id_exe_pipe[3] && lsu_count_q == CW'(LSU_MAX_OUTSTANDING));
  // reset gates the request so outputs are quiet while rst is low
  assign req        = rst && sb.id_valid && !sb.flush && sb.id_exe_pipe != '0;
  assign can_issue  = req && !raw && !waw && !struct_blk;
  always_comb begin
    set_mask = '0;
    if (can_issue && sb.id_register_write && sb.id_rd != '0) set_mask[sb.id_rd] = 1'b1;
  end
  assign busy_d      = (busy_q & ~clr_mask) | set_mask;
  assign div_busy_d  = (can_issue && sb.id_exe_pipe[2]) ? 1'b1 : sb.wb_valid[2] ? 1'b0 : div_busy_q;
  assign lsu_inc     = can_issue && sb.id_exe_pipe[3];
  assign lsu_dec     = sb.lsu_done && lsu_count_q != '0;
  assign lsu_count_d = (lsu_inc && !lsu_dec) ? lsu_count_q + CW'(1) :
                       (lsu_dec && !lsu_inc) ? lsu_count_q - CW'(1) : lsu_count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      div_busy_q  <= 1'b0;
      lsu_count_q <= '0;
    end else begin
      busy_q      <= busy_d;
      div_busy_q  <= div_busy_d;
      lsu_count_q <= lsu_count_d;
    end
  end
  assign sb.issue_valid = can_issue ? sb.id_exe_pipe : 4'b0000;
  assign sb.stall       = req && !can_issue;
  assign sb.busy_regs   = busy_q;
  assign sb.div_busy    = div_busy_q;
endmodule
